imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: 16-bit word count, then big-endian words written to instruction memory.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int unsigned MAX_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE, LEN_HI, LEN_LO, DATA, WRITE, FIN
`ifdef IMEM_LOADER_CHECKSUM_EN
      , CHK
`endif
   } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t END_STATE = CHK;
`else
   localparam state_t END_STATE = FIN;
`endif

   localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

   state_t      state, state_nxt;
   logic [15:0] count;
   logic [15:0] idx;
   logic [31:0] word;
   logic [1:0]  bcnt;
   logic        xfer;
   logic [15:0] n_full;
   logic        oversize;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  chk;
`endif

   assign xfer     = in_valid & in_ready;
   assign n_full   = {count[15:8], in_data};
   assign oversize = {1'b0, n_full} > MAX_W;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (load_start) state_nxt = LEN_HI;
         LEN_HI: if (xfer) state_nxt = LEN_LO;
         LEN_LO: if (xfer) begin
            if (n_full == 16'd0) state_nxt = END_STATE;
            else if (oversize)   state_nxt = FIN;
            else                 state_nxt = DATA;
         end
         DATA:   if (xfer && bcnt == 2'd3) state_nxt = WRITE;
         WRITE:  state_nxt = (idx == count - 16'd1) ? END_STATE : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHK:    if (xfer) state_nxt = FIN;
`endif
         FIN:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      imem_we  = 1'b0;
      done     = 1'b0;
      busy     = (state != IDLE);
      case (state)
         LEN_HI, LEN_LO, DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHK:                  in_ready = 1'b1;
`endif
         WRITE:                imem_we  = 1'b1;
         FIN:                  done     = 1'b1;
         default: ;
      endcase
   end

   // Address/data are captured with the 4th byte so they are stable during WRITE and hold afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count      <= '0;
         idx        <= '0;
         word       <= '0;
         bcnt       <= '0;
         imem_addr  <= BASE_ADDR;
         imem_wdata <= '0;
         err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         chk        <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (load_start) begin
               err  <= 1'b0;
               idx  <= '0;
               bcnt <= '0;
               word <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               chk  <= '0;
`endif
            end
            LEN_HI: if (xfer) count[15:8] <= in_data;
            LEN_LO: if (xfer) begin
               count[7:0] <= in_data;
               if (oversize) err <= 1'b1;
            end
            DATA: if (xfer) begin
               word <= {word[23:0], in_data};
               bcnt <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               chk  <= chk ^ in_data;
`endif
               if (bcnt == 2'd3) begin
                  imem_addr  <= BASE_ADDR + {14'd0, idx, 2'b00};
                  imem_wdata <= {word[23:0], in_data};
               end
            end
            WRITE: idx <= idx + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: if (xfer && in_data != chk) err <= 1'b1;
`endif
            default: ;
         endcase
      end
   end

endmodule
